// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter (SLL/SRL/SRA, optional ROL) moving at most STEP bits per cycle, valid/ready on both sides.
// Define SHIFT_ROTATE_EN to build the rotate-left datapath for Op 2'b11; otherwise Op 2'b11 behaves as SLL.
module shift_unit_seq #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   B,
  input  logic [1:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carryout,
  output logic             Overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_ROTATE_EN
  localparam logic [1:0] OP_ROL = 2'b11;
`endif

  // Counts are one bit wider than SHW so that STEP == WIDTH is representable.
  localparam logic [SHW:0]       WIDTH_C = (SHW+1)'(WIDTH);
  localparam logic [SHW:0]       STEP_C  = (SHW+1)'(STEP);
  localparam logic [SHW:0]       ONE_C   = (SHW+1)'(1);
  localparam logic [WIDTH-1:0]   ONES_C  = {WIDTH{1'b1}};

  state_e             state_r, state_s;
  logic [WIDTH-1:0]   work_r;
  logic [1:0]         op_r;
  logic [SHW-1:0]     rem_r;
  logic               sign_r;
  logic               carry_r;
  logic               ovf_r;

  logic [SHW:0]       rem_ext_s;
  logic [SHW:0]       k_s;
  logic [SHW-1:0]     hi_idx_s;
  logic [SHW-1:0]     lo_idx_s;
  logic [SHW-1:0]     rem_next_s;
  logic [WIDTH-1:0]   out_mask_s;
  logic [WIDTH-1:0]   step_res_s;
  logic               step_carry_s;
  logic               step_ovf_s;
  logic               last_step_s;

  // One shift step of k = min(remaining, STEP) bits, with its carry and overflow contribution.
  always_comb begin
    rem_ext_s    = {1'b0, rem_r};
    k_s          = (rem_ext_s > STEP_C) ? STEP_C : rem_ext_s;
    last_step_s  = (rem_ext_s <= STEP_C);
    rem_next_s   = SHW'(rem_ext_s - k_s);
    hi_idx_s     = SHW'(WIDTH_C - k_s);
    lo_idx_s     = SHW'(k_s - ONE_C);
    out_mask_s   = ~(ONES_C >> k_s);
    step_res_s   = work_r << k_s;
    step_carry_s = work_r[hi_idx_s];
    step_ovf_s   = 1'b0;
    case (op_r)
      OP_SRL: begin
        step_res_s   = work_r >> k_s;
        step_carry_s = work_r[lo_idx_s];
      end
      OP_SRA: begin
        step_res_s   = $unsigned($signed(work_r) >>> k_s);
        step_carry_s = work_r[lo_idx_s];
      end
`ifdef SHIFT_ROTATE_EN
      OP_ROL: begin
        step_res_s   = (work_r << k_s) | (work_r >> (WIDTH_C - k_s));
        step_carry_s = work_r[hi_idx_s];
      end
`endif
      default: begin
        // SLL: any departed bit or the new MSB disagreeing with the original sign is overflow.
        step_ovf_s = (sign_r ? (|(~work_r & out_mask_s)) : (|(work_r & out_mask_s)))
                   | (step_res_s[WIDTH-1] ^ sign_r);
      end
    endcase
  end

  // Next-state decode for the IDLE/BUSY/DONE handshake sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = (B == {SHW{1'b0}}) ? ST_DONE : ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_step_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Working datapath: latch on accept, step while busy, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r  <= {WIDTH{1'b0}};
      op_r    <= 2'b00;
      rem_r   <= {SHW{1'b0}};
      sign_r  <= 1'b0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (state_r == ST_IDLE && in_valid) begin
      work_r  <= A;
      op_r    <= Op;
      rem_r   <= B;
      sign_r  <= A[WIDTH-1];
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (state_r == ST_BUSY) begin
      work_r  <= step_res_s;
      rem_r   <= rem_next_s;
      carry_r <= step_carry_s;
      ovf_r   <= ovf_r | step_ovf_s;
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign Result    = work_r;
  assign Carryout  = carry_r;
  assign Overflow  = ovf_r;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed test-plan vectors plus randomized requests
// compared every cycle against a whole-shift arithmetic reference model.
module tb_shift_unit_seq;

  localparam int W    = 32;
  localparam int STEP = 4;
  localparam int SHW  = $clog2(W);

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   A         = '0;
  logic [SHW-1:0] B         = '0;
  logic [1:0]     Op        = 2'b00;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   Result;
  logic           Carryout;
  logic           Overflow;

  int total    = 0;
  int bad      = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  shift_unit_seq #(.WIDTH(W), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Carryout(Carryout), .Overflow(Overflow)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int exp_latency(input int b);
    return 1 + (b + STEP - 1) / STEP;
  endfunction

  // Whole-shift reference: returns {result, carry, overflow}.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input int b, input logic [1:0] op_in);
    logic [1:0]     op;
    logic [W-1:0]   r;
    logic [W-1:0]   back;
    logic [2*W-1:0] dbl;
    logic           c;
    logic           o;
    op = op_in;
`ifndef SHIFT_ROTATE_EN
    if (op == 2'b11) op = 2'b00;
`endif
    r = '0; c = 1'b0; o = 1'b0;
    case (op)
      2'b00: begin
        r = a << b;
        if (b > 0) c = a[W-b];
        back = $signed(r) >>> b;
        o = (back != a);
      end
      2'b01: begin
        r = a >> b;
        if (b > 0) c = a[b-1];
      end
      2'b10: begin
        r = $signed(a) >>> b;
        if (b > 0) c = a[b-1];
      end
      default: begin
        dbl = {a, a} << b;
        r = dbl[2*W-1:W];
        if (b > 0) c = r[0];
      end
    endcase
    return {r, c, o};
  endfunction

  logic         m_busy  = 1'b0;
  logic         m_valid = 1'b0;
  int           m_left  = 0;
  logic [W-1:0] m_res   = '0;
  logic         m_c     = 1'b0;
  logic         m_o     = 1'b0;

  // Cycle-level expectation: result appears exp_latency edges after accept, held until out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_left <= 0;
      m_res <= '0; m_c <= 1'b0; m_o <= 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
      end
    end else if (in_valid) begin
      {m_res, m_c, m_o} <= ref_model(A, int'(B), Op);
      m_left  <= exp_latency(int'(B)) - 1;
      m_valid <= (exp_latency(int'(B)) == 1);
      m_busy  <= (exp_latency(int'(B)) > 1);
    end
  end

  // Single compare process against the model on every falling edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready", in_ready, !(m_busy || m_valid));
      chk("out_valid", out_valid, m_valid);
      if (m_valid && out_valid) begin
        chk("Result", Result, m_res);
        chk("Carryout", Carryout, m_c);
        chk("Overflow", Overflow, m_o);
      end
    end
  end

  // Called at a falling edge; returns the captured outputs, latency and cycles waited for in_ready.
  task automatic send(input logic [W-1:0] a, input logic [SHW-1:0] b, input logic [1:0] op, input int hold,
                      output logic [W-1:0] r, output logic c, output logic o, output int lat, output int waited);
    A = a; B = b; Op = op; in_valid = 1'b1; waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_latency(int'(b)));
    r = Result; c = Carryout; o = Overflow;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r;
    logic         c, o;
    int           lat, waited;

    repeat (2) @(negedge clk);
    chk("rst_Result", Result, 0);
    chk("rst_Carryout", Carryout, 0);
    chk("rst_Overflow", Overflow, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    checking = 1'b1;
    @(negedge clk);

    send(32'h0000_0001, 5'd31, 2'b00, 0, r, c, o, lat, waited);
    chk("sll31_res", r, 32'h8000_0000); chk("sll31_c", c, 0); chk("sll31_o", o, 1); chk("sll31_lat", lat, 9);

    send(32'h8000_00F8, 5'd4, 2'b10, 0, r, c, o, lat, waited);
    chk("sra4_res", r, 32'hF800_000F); chk("sra4_c", c, 1); chk("sra4_o", o, 0); chk("sra4_lat", lat, 2);

    send(32'h1234_5678, 5'd0, 2'b01, 0, r, c, o, lat, waited);
    chk("srl0_res", r, 32'h1234_5678); chk("srl0_c", c, 0); chk("srl0_o", o, 0); chk("srl0_lat", lat, 1);

    send(32'h8000_0001, 5'd1, 2'b11, 0, r, c, o, lat, waited);
`ifdef SHIFT_ROTATE_EN
    chk("rol1_res", r, 32'h0000_0003); chk("rol1_c", c, 1); chk("rol1_o", o, 0);
`else
    chk("op3_res", r, 32'h0000_0002); chk("op3_c", c, 1); chk("op3_o", o, 1);
`endif

    // Backpressure, then an immediate follow-up request
    send(32'hA5A5_0F0F, 5'd7, 2'b01, 5, r, c, o, lat, waited);
    chk("bp_res", r, 32'h014B_4A1E);
    chk("bp_in_ready_after", in_ready, 1);
    send(32'h0000_000F, 5'd2, 2'b00, 0, r, c, o, lat, waited);
    chk("b2b_waited", waited, 0); chk("b2b_res", r, 32'h0000_003C); chk("b2b_o", o, 0);

    // Reset in the middle of a long SLL
    A = 32'h0000_0001; B = 5'd20; Op = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_Result", Result, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h0000_00F0, 5'd4, 2'b01, 0, r, c, o, lat, waited);
    chk("postrst_res", r, 32'h0000_000F); chk("postrst_c", c, 0);

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0]   ra;
      logic [SHW-1:0] rb;
      ra = $urandom;
      rb = SHW'($urandom_range(0, W-1));
      if (i % 17 == 0) rb = '0;
      if (i % 13 == 0) rb = SHW'(W-1);
      send(ra, rb, 2'($urandom_range(0, 3)), $urandom_range(0, 3), r, c, o, lat, waited);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised multi-cycle shifter for the ALU datapath, replacing the fixed 32-bit single-cycle left shifter. It supports logical left, logical right and arithmetic right shifts, plus rotate-left when configured. Each cycle it shifts by at most `STEP` bits. It carries `Carryout`/`Overflow` semantics and uses valid/ready handshakes on both sides, so it can sit behind the ALU op decoder in a multi-cycle or stalled pipeline.

## Interface
- `WIDTH`, 32: data width; power of two, ≥ 8.
- `STEP`, 4: maximum bits shifted per cycle; power of two, 1..WIDTH.
- `SHW`, $clog2(WIDTH): shift-amount width. Localparam, not overridable.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `A`  in  WIDTH  operand to shift.
- `B`  in  SHW  shift amount (unsigned).
- `Op`  in  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = ROL.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `Result`  out  WIDTH  shifted value.
- `Carryout`  out  1  last bit shifted or rotated out.
- `Overflow`  out  1  signed overflow, SLL only.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). The block handles one request at a time; there is no overlap.
- **IDLE**, on `in_valid && in_ready`:
  - Latch `A` into the working register, `Op` into the op register and `B` into the remaining-count register.
  - Clear the carry and overflow flags.
  - If `B == 0`, go to DONE; otherwise go to BUSY.
- **BUSY**, each cycle:
  - Shift amount k = min(remaining, STEP).
  - SLL: shift left by k, zero fill.
  - SRL: shift right by k, zero fill.
  - SRA: shift right by k, fill with the bit currently at the MSB of the working register, which equals original `A[WIDTH-1]`.
  - ROL: rotate left by k.
  - Carry flag is overwritten with the last bit leaving the word:
    - SLL/ROL: bit WIDTH-k before the step.
    - SRL/SRA: bit k-1 before the step.
  - SLL overflow flag is sticky. Set it if any bit shifted out differs from original `A[WIDTH-1]`, or if the new MSB differs from it. The flag is 0 for every other op.
  - Update remaining -= k. When it reaches 0, go to DONE.
- **DONE**:
  - `Result`, `Carryout` and `Overflow` drive from the registers and hold stable until the handshake.
  - On `out_ready`, return to IDLE.
- Shift amounts are taken modulo WIDTH by construction, because `B` is SHW bits wide.
- `Carryout` is 0 when `B == 0`.
- Reset asserted in any state forces IDLE immediately, and the in-flight operation is discarded.

## Timing
- Reset values: `Result` = 0, `Carryout` = 0, `Overflow` = 0, `out_valid` = 0, `in_ready` = 1.
- Latency from the accepting edge to `out_valid` = 1 + ceil(`B`/STEP) cycles. Examples: `B == 0` gives 1 cycle; WIDTH=32, STEP=4, `B` = 31 gives 9 cycles.
- Throughput: one result per (latency + 1) cycles with `out_ready` held high. The extra cycle is DONE→IDLE.
- `in_ready` is low from the cycle after acceptance until the cycle after the output handshake.
- `out_ready` is ignored outside DONE.
- Outputs are registered, with no combinational path from inputs to outputs. `in_ready` and `out_valid` decode state only.

## Configuration
- `SHIFT_ROTATE_EN`:
  - Defined: Op 11 performs ROL as described in Operation.
  - Undefined: Op 11 is decoded as SLL, including overflow, and no rotate datapath is built.

## Test plan
- SLL, A=0x00000001, B=31, WIDTH=32, STEP=4 -> Result 0x80000000, Carryout 0, Overflow 1, `out_valid` exactly 9 cycles after accept.
- SRA, A=0x800000F8, B=4 -> Result 0xF800000F, Carryout 1, Overflow 0, latency 2.
- SRL, A=0x12345678, B=0 -> Result 0x12345678, Carryout 0, Overflow 0, latency 1.
- ROL with `SHIFT_ROTATE_EN`, A=0x80000001, B=1 -> Result 0x00000003, Carryout 1. Without the macro, the same stimulus -> Result 0x00000002, Carryout 1, Overflow 1.
- Backpressure: hold `out_ready` low 5 cycles in DONE -> Result and flags stable, `in_ready` 0. Raise `out_ready` -> IDLE next cycle, and a new request is accepted the cycle after.
- Reset mid-BUSY, during a B=20 SLL -> `out_valid` 0, Result 0, `in_ready` 1 immediately. A following SRL A=0xF0, B=4 -> Result 0x0F.
